// File: rtl/pll_lock_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : pll_lock_sequencer_if
// Brief  : Phase-detector sample stream in, loop-control status out.
// Rev    : 1.0  initial release
// ============================================================================
interface pll_lock_sequencer_if;
    logic        enable;
    logic [15:0] phase_error;
    logic        error_valid;
    logic        rate_change;
    logic [1:0]  bandwidth;
    logic        pll_locked;
    logic        filter_reset;
    logic        lock_lost;
    logic        acq_timeout;
    logic [2:0]  state;

    modport master (
        output enable, phase_error, error_valid, rate_change,
        input  bandwidth, pll_locked, filter_reset, lock_lost, acq_timeout, state
    );

    modport slave (
        input  enable, phase_error, error_valid, rate_change,
        output bandwidth, pll_locked, filter_reset, lock_lost, acq_timeout, state
    );
endinterface
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pll_lock_sequencer
// Brief  : Acquire/settle/track lock sequencer driving loop-filter bandwidth.
// Rev    : 1.0  initial release
// ============================================================================
module pll_lock_sequencer #(
    parameter logic [15:0] LOCK_WIN    = 16'd1024,
    parameter int          LOCK_CNT    = 32,
    parameter int          SETTLE_CNT  = 64,
    parameter int          LOSS_CNT    = 8,
    parameter int          ACQ_TIMEOUT = 4096
) (
    input  wire logic           clk,
    input  wire logic           reset,
    pll_lock_sequencer_if.slave bus
);
    localparam int GOOD_MAX = (LOCK_CNT > SETTLE_CNT) ? LOCK_CNT : SETTLE_CNT;
    localparam int GW       = $clog2(GOOD_MAX + 1);
    localparam int BW       = $clog2(LOSS_CNT + 1);
    localparam int SW       = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [GW-1:0] C_LOCK_CNT   = GW'(LOCK_CNT);
    localparam logic [GW-1:0] C_SETTLE_CNT = GW'(SETTLE_CNT);
    localparam logic [BW-1:0] C_LOSS_CNT   = BW'(LOSS_CNT);
    localparam logic [SW-1:0] C_ACQ_TO     = SW'(ACQ_TIMEOUT);

    localparam logic [2:0] C_IDLE    = 3'd0;
    localparam logic [2:0] C_ACQUIRE = 3'd1;
    localparam logic [2:0] C_SETTLE  = 3'd2;
    localparam logic [2:0] C_TRACK   = 3'd3;
    localparam logic [2:0] C_LOST    = 3'd4;

    logic [2:0]    r_state;
    logic [GW-1:0] r_good_cnt;
    logic [BW-1:0] r_bad_cnt;
    logic [SW-1:0] r_sample_cnt;
    logic          r_pll_locked;
    logic          r_filter_reset;
    logic          r_lock_lost;
    logic          r_acq_timeout;

    logic [16:0]   w_ext;
    logic [16:0]   w_mag;
    logic          w_good;
    logic          w_sample;
    logic [GW-1:0] w_good_inc;
    logic [BW-1:0] w_bad_inc;
    logic [SW-1:0] w_sample_inc;
    logic [2:0]    w_next_state;
    logic          w_clear;
    logic          w_filter_reset;
    logic          w_lock_lost;
    logic          w_set_timeout;

    // 17-bit magnitude so that -32768 maps to +32768 and is never good
    assign w_ext  = {bus.phase_error[15], bus.phase_error};
    assign w_mag  = bus.phase_error[15] ? (17'd0 - w_ext) : w_ext;
    assign w_good = (w_mag < {1'b0, LOCK_WIN});

    assign w_sample     = bus.enable && bus.error_valid;
    assign w_good_inc   = (r_good_cnt   == '1) ? r_good_cnt   : r_good_cnt   + GW'(1);
    assign w_bad_inc    = (r_bad_cnt    == '1) ? r_bad_cnt    : r_bad_cnt    + BW'(1);
    assign w_sample_inc = (r_sample_cnt == '1) ? r_sample_cnt : r_sample_cnt + SW'(1);

    always_comb begin
        w_next_state   = r_state;
        w_clear        = 1'b0;
        w_filter_reset = 1'b0;
        w_lock_lost    = 1'b0;
        w_set_timeout  = 1'b0;
        if (!bus.enable) begin
            w_next_state = C_IDLE;
            w_clear      = 1'b1;
        end else if (bus.rate_change && (r_state != C_IDLE)) begin
            // Zone change restarts acquisition but keeps the integrator
            w_next_state = C_ACQUIRE;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                C_IDLE: begin
                    w_next_state   = C_ACQUIRE;
                    w_clear        = 1'b1;
                    w_filter_reset = 1'b1;
                end
                C_ACQUIRE, C_LOST: begin
                    if (w_sample) begin
                        if (w_good && (w_good_inc >= C_LOCK_CNT)) begin
                            w_next_state = C_SETTLE;
                            w_clear      = 1'b1;
                        end else if (w_sample_inc >= C_ACQ_TO) begin
                            w_next_state   = C_ACQUIRE;
                            w_clear        = 1'b1;
                            w_filter_reset = 1'b1;
                            w_set_timeout  = 1'b1;
                        end
                    end
                end
                C_SETTLE: begin
                    if (w_sample) begin
                        if (w_good && (w_good_inc >= C_SETTLE_CNT)) begin
                            w_next_state = C_TRACK;
                            w_clear      = 1'b1;
                        end else if (!w_good && (w_bad_inc >= C_LOSS_CNT)) begin
                            w_next_state = C_ACQUIRE;
                            w_clear      = 1'b1;
                        end
                    end
                end
                C_TRACK: begin
                    if (w_sample && !w_good && (w_bad_inc >= C_LOSS_CNT)) begin
                        w_next_state = C_LOST;
                        w_clear      = 1'b1;
                        w_lock_lost  = 1'b1;
                    end
                end
                default: begin
                    w_next_state = C_IDLE;
                    w_clear      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= C_IDLE;
            r_good_cnt     <= '0;
            r_bad_cnt      <= '0;
            r_sample_cnt   <= '0;
            r_pll_locked   <= 1'b0;
            r_filter_reset <= 1'b0;
            r_lock_lost    <= 1'b0;
            r_acq_timeout  <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_pll_locked   <= (w_next_state == C_TRACK);
            r_filter_reset <= w_filter_reset;
            r_lock_lost    <= w_lock_lost;
            if (!bus.enable) begin
                r_acq_timeout <= 1'b0;
            end else if (w_set_timeout) begin
                r_acq_timeout <= 1'b1;
            end
            if (w_clear) begin
                r_good_cnt   <= '0;
                r_bad_cnt    <= '0;
                r_sample_cnt <= '0;
            end else if (w_sample) begin
                if (w_good) begin
                    r_good_cnt <= w_good_inc;
                    r_bad_cnt  <= '0;
                end else begin
                    r_bad_cnt  <= w_bad_inc;
                    r_good_cnt <= '0;
                end
                if ((r_state == C_ACQUIRE) || (r_state == C_LOST)) begin
                    r_sample_cnt <= w_sample_inc;
                end
            end
        end
    end

    always_comb begin
        case (r_state)
            C_SETTLE: bus.bandwidth = 2'b01;
            C_TRACK:  bus.bandwidth = 2'b00;
            C_LOST:   bus.bandwidth = 2'b10;
            default:  bus.bandwidth = 2'b11;
        endcase
    end

    assign bus.state        = r_state;
    assign bus.pll_locked   = r_pll_locked;
    assign bus.filter_reset = r_filter_reset;
    assign bus.lock_lost    = r_lock_lost;
    assign bus.acq_timeout  = r_acq_timeout;

endmodule
`default_nettype wire
